// File: rtl/bit_scan_serializer.sv
// bit_scan_serializer: streams each set bit of an accepted word as a one-hot beat with its index,
// in LSB-first or MSB-first order chosen per word.
module bit_scan_serializer #(
    parameter int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             msb_first_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] index_o,
    output logic [IDX_W:0]   ordinal_o,
    output logic             last_o,
    output logic             zero_o,
    output logic             data_val_o,
    input  logic             data_ready_i
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] rem_d;
    logic             mode_q;
    logic [IDX_W:0]   ordinal_q;
    logic             zero_q;
    logic [IDX_W-1:0] lo_idx;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] idx;
    logic             scan;
    logic             accept;
    logic             handshake;
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) if (rem_q[i]) lo_idx = IDX_W'(i);
        for (int i = 0; i < WIDTH; i++) if (rem_q[i]) hi_idx = IDX_W'(i);
    end
    assign scan         = state_q == SCAN;
    assign idx          = mode_q ? hi_idx : lo_idx;
    assign onehot_o     = (scan && rem_q != '0) ? (WIDTH'(1) << idx) : '0;
    assign index_o      = scan ? idx : '0;
    assign ordinal_o    = scan ? ordinal_q : '0;
    // A single remaining set bit (rem & (rem-1) == 0) marks the final beat.
    assign last_o       = scan && (zero_q || (rem_q & (rem_q - WIDTH'(1))) == '0);
    assign zero_o       = scan && zero_q;
    assign data_val_o   = scan;
    assign data_ready_o = !scan || (last_o && data_ready_i);
    assign accept       = data_val_i && data_ready_o;
    assign handshake    = scan && data_ready_i;
    assign rem_d        = rem_q & ~onehot_o;
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            mode_q    <= 1'b0;
            ordinal_q <= '0;
            zero_q    <= 1'b0;
        end else if (accept) begin
            state_q   <= SCAN;
            rem_q     <= data_i;
            mode_q    <= msb_first_i;
            ordinal_q <= '0;
            zero_q    <= data_i == '0;
        end else if (handshake) begin
            rem_q     <= rem_d;
            ordinal_q <= ordinal_q + 1'b1;
            if (last_o) state_q <= IDLE;
        end
    end
endmodule
